// File: rtl/gc_dram_pkg.sv
// Shared types and default geometry for the gain-cell DRAM controller,
// bank wrappers and per-bank refresh sequencers.
package gc_dram_pkg;

    localparam int ROWS = 128;
    localparam int AW   = 7;
    localparam int DW   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } ref_state_t;

endpackage

// File: rtl/ref_row_counter.sv
// Row pointer for one refresh pass: clear on start, step on each completed
// write-back, and saturate at the last row instead of wrapping.
import gc_dram_pkg::*;

module ref_row_counter #(
    parameter int ROWS = gc_dram_pkg::ROWS,
    parameter int AW   = gc_dram_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] row,
    output logic          last
);

    assign last = (row == AW'(ROWS - 1));

    // Clear wins over increment; never advance past the last row.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
        end else if (inc && !last) begin
            row <= row + AW'(1);
        end
    end

endmodule

// File: rtl/bank_refresh_sequencer.sv
// Per-bank refresh engine: walks every row (read, then write the same data
// back) and shares the bank's array ports with the external access path.
import gc_dram_pkg::*;

module bank_refresh_sequencer #(
    parameter int ROWS = gc_dram_pkg::ROWS,
    parameter int AW   = gc_dram_pkg::AW,
    parameter int DW   = gc_dram_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_sr,
    input  logic          we_ext,
    input  logic          re_ext,
    input  logic [AW-1:0] waddr_ext,
    input  logic [AW-1:0] raddr_ext,
    input  logic [DW-1:0] wdata_ext,
    input  logic [DW-1:0] arr_rd,
    output logic          arr_we,
    output logic          arr_re,
    output logic [AW-1:0] arr_waddr,
    output logic [AW-1:0] arr_raddr,
    output logic [DW-1:0] arr_wdata,
    output logic          ref_done,
    output logic          offs_ref_re,
    output logic          busy
);

    ref_state_t    state;
    logic [DW-1:0] cap_q;     // row data held across write-back stalls
    logic          wb_first;  // first WB cycle: read data is on arr_rd right now
    logic [AW-1:0] row;
    logic          last;
    logic          wb_stall;
    logic          wb_adv;
    logic [DW-1:0] wb_data;

    // An external write to another row owns the write port: hold and retry.
    // An external write to this row carries fresher data, so the row counts as done.
    assign wb_stall = we_ext && (waddr_ext != row);
    assign wb_adv   = (state == WB) && !wb_stall;
    assign wb_data  = wb_first ? arr_rd : cap_q;

    ref_row_counter #(
        .ROWS (ROWS),
        .AW   (AW)
    ) u_row_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state == IDLE) && start_sr),
        .inc  (wb_adv),
        .row  (row),
        .last (last)
    );

    // Refresh state machine and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cap_q    <= '0;
            wb_first <= 1'b0;
        end else begin
            wb_first <= 1'b0;
            case (state)
                IDLE: if (start_sr) state <= RD;
                RD: begin
                    state    <= WB;
                    wb_first <= 1'b1;
                end
                WB: begin
                    if (wb_first) cap_q <= arr_rd;
                    if (!wb_stall) state <= last ? DONE : RD;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Port steering: external path by default, refresh takes one port per phase.
    always_comb begin
        arr_we      = we_ext;
        arr_re      = re_ext;
        arr_waddr   = waddr_ext;
        arr_raddr   = raddr_ext;
        arr_wdata   = wdata_ext;
        ref_done    = 1'b0;
        offs_ref_re = 1'b0;
        busy        = (state != IDLE);
        case (state)
            RD: begin
                arr_re      = 1'b1;
                arr_raddr   = row;
                offs_ref_re = 1'b1;
            end
            WB: begin
                if (!we_ext) begin
                    arr_we    = 1'b1;
                    arr_waddr = row;
                    arr_wdata = wb_data;
                end
            end
            DONE:    ref_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bank_refresh_sequencer.sv
// Bench for bank_refresh_sequencer: behavioural array model, directed passes,
// and a ref_done scoreboard checked by an independent monitor.
import gc_dram_pkg::*;

module tb_bank_refresh_sequencer;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_sr;
    logic          we_ext, re_ext;
    logic [AW-1:0] waddr_ext, raddr_ext;
    logic [DW-1:0] wdata_ext;
    logic [DW-1:0] arr_rd;
    logic          arr_we, arr_re;
    logic [AW-1:0] arr_waddr, arr_raddr;
    logic [DW-1:0] arr_wdata;
    logic          ref_done, offs_ref_re, busy;

    bank_refresh_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start_sr    (start_sr),
        .we_ext      (we_ext),
        .re_ext      (re_ext),
        .waddr_ext   (waddr_ext),
        .raddr_ext   (raddr_ext),
        .wdata_ext   (wdata_ext),
        .arr_rd      (arr_rd),
        .arr_we      (arr_we),
        .arr_re      (arr_re),
        .arr_waddr   (arr_waddr),
        .arr_raddr   (arr_raddr),
        .arr_wdata   (arr_wdata),
        .ref_done    (ref_done),
        .offs_ref_re (offs_ref_re),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Array model: synchronous read (data next cycle), write tracking per row.
    logic [DW-1:0]   mem [ROWS];
    logic [DW-1:0]   rd_q = '0;
    logic [ROWS-1:0] written = '0;
    logic            wr_clr = 1'b0;
    assign arr_rd = rd_q;
    always @(posedge clk) begin
        if (arr_we) mem[arr_waddr] <= arr_wdata;
        if (arr_re) rd_q <= mem[arr_raddr];
        if (wr_clr) written <= '0;
        else if (arr_we) written[arr_waddr] <= 1'b1;
    end

    logic [DW-1:0] exp_mem [ROWS];
    int total = 0;
    int bad = 0;
    int done_q[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    // Issue a start pulse at the current negedge; optionally book a ref_done.
    task automatic pulse_start(input bit expect_done, input int stalls, output int c0);
        c0 = cyc;
        start_sr = 1'b1;
        if (expect_done) done_q.push_back(c0 + 2 * ROWS + 1 + stalls);
        step();
        start_sr = 1'b0;
    endtask

    task automatic check_mem(input string nm);
        int mism = 0;
        int first = -1;
        for (int r = 0; r < ROWS; r++) begin
            if (mem[r] !== exp_mem[r]) begin
                mism++;
                if (first < 0) first = r;
            end
        end
        chk({nm, "_mem_mismatch_rows"}, 64'(mism), 64'd0);
        if (first >= 0) $display("  first bad row %0d: %h vs %h", first, mem[first], exp_mem[first]);
        chk({nm, "_rows_written"}, 64'(written), {64{1'b1}});
    endtask

    task automatic clear_written();
        wr_clr = 1'b1;
        step();
        wr_clr = 1'b0;
    endtask

    // Monitor: every ref_done pops the scoreboard; busy must drop the next cycle.
    bit busy_chk = 1'b0;
    always @(negedge clk) begin
        if (busy_chk) begin
            chk("busy_after_done", 64'(busy), 64'd0);
            busy_chk = 1'b0;
        end
        if (ref_done) begin
            if (done_q.size() == 0) begin
                chk("spurious_ref_done_cycle", 64'(cyc), 64'd0);
            end else begin
                chk("ref_done_cycle", 64'(cyc), 64'(done_q.pop_front()));
            end
            chk("busy_at_done", 64'(busy), 64'd1);
            busy_chk = 1'b1;
        end
    end

    int c0;

    initial begin
        rst = 1'b1; start_sr = 1'b0; we_ext = 1'b0; re_ext = 1'b0;
        waddr_ext = '0; raddr_ext = '0; wdata_ext = '0;

        // Reset and idle pass-through.
        repeat (3) step();
        #1;
        chk("reset_outputs", 64'({arr_we, arr_re, arr_waddr, arr_raddr, ref_done, offs_ref_re, busy}), 64'd0);
        chk("reset_wdata", arr_wdata, 64'd0);
        rst = 1'b0;
        step();
        we_ext = 1'b1; waddr_ext = 7'd5; wdata_ext = 64'hA5;
        re_ext = 1'b1; raddr_ext = 7'd7;
        #1;
        chk("idle_we", 64'(arr_we), 64'd1);
        chk("idle_waddr", 64'(arr_waddr), 64'd5);
        chk("idle_wdata", arr_wdata, 64'hA5);
        chk("idle_raddr", 64'(arr_raddr), 64'd7);
        step();
        re_ext = 1'b0;

        // Preload row r with r*0x0101 through the idle pass-through.
        for (int r = 0; r < ROWS; r++) begin
            we_ext = 1'b1; waddr_ext = AW'(r); wdata_ext = 64'(r * 16'h0101);
            exp_mem[r] = 64'(r * 16'h0101);
            step();
        end
        we_ext = 1'b0;
        clear_written();

        // Clean pass; a start during DONE must be ignored.
        pulse_start(1'b1, 0, c0);
        #1;
        chk("p1_rd0_offs", 64'(offs_ref_re), 64'd1);
        chk("p1_rd0_raddr", 64'({arr_re, arr_raddr}), {56'd0, 1'b1, 7'd0});
        wait_to(c0 + 3); #1;
        chk("p1_rd1_raddr", 64'({offs_ref_re, arr_raddr}), {56'd0, 1'b1, 7'd1});
        step(); #1;
        chk("p1_wb1_offs", 64'(offs_ref_re), 64'd0);
        chk("p1_wb1_waddr", 64'({arr_we, arr_waddr}), {56'd0, 1'b1, 7'd1});
        chk("p1_wb1_wdata", arr_wdata, 64'h0101);
        wait_to(c0 + 2 * ROWS + 1);
        start_sr = 1'b1;
        step();
        start_sr = 1'b0;
        step(); step();
        check_mem("p1");
        clear_written();

        // Same-row conflict at WB of row 10: external data wins, no stall.
        pulse_start(1'b1, 0, c0);
        wait_to(c0 + 22);
        we_ext = 1'b1; waddr_ext = 7'd10; wdata_ext = 64'hDEAD;
        exp_mem[10] = 64'hDEAD;
        #1;
        chk("p2_ext_wdata", arr_wdata, 64'hDEAD);
        step();
        we_ext = 1'b0;
        #1;
        chk("p2_next_rd_row", 64'({offs_ref_re, arr_raddr}), {56'd0, 1'b1, 7'd11});
        wait_to(c0 + 2 * ROWS + 3);
        check_mem("p2");
        clear_written();

        // Different-row conflict for 2 cycles at WB of row 20.
        pulse_start(1'b1, 2, c0);
        wait_to(c0 + 42);
        we_ext = 1'b1; waddr_ext = 7'd3; wdata_ext = 64'h3333_BEEF;
        exp_mem[3] = 64'h3333_BEEF;
        step(); #1;
        chk("p3_stall_waddr", 64'({offs_ref_re, arr_waddr}), {56'd0, 1'b0, 7'd3});
        step();
        we_ext = 1'b0;
        #1;
        chk("p3_retry_waddr", 64'({arr_we, arr_waddr}), {56'd0, 1'b1, 7'd20});
        chk("p3_retry_wdata", arr_wdata, exp_mem[20]);
        step(); #1;
        chk("p3_next_rd_row", 64'(arr_raddr), 64'd21);
        wait_to(c0 + 2 * ROWS + 5);
        check_mem("p3");
        clear_written();

        // Read steering, ignored restart, then abort by reset.
        pulse_start(1'b0, 0, c0);
        re_ext = 1'b1; raddr_ext = 7'd99;
        #1;
        chk("steer_rd", 64'({arr_re, offs_ref_re, arr_raddr}), {55'd0, 2'b11, 7'd0});
        step(); #1;
        chk("steer_wb", 64'({arr_re, offs_ref_re, arr_raddr}), {55'd0, 2'b10, 7'd99});
        re_ext = 1'b0;
        wait_to(c0 + 101);
        start_sr = 1'b1;
        step();
        start_sr = 1'b0;
        step(); #1;
        chk("restart_ignored_row", 64'({offs_ref_re, arr_raddr}), {56'd0, 1'b1, 7'd51});
        wait_to(c0 + 121);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_idle", 64'({busy, offs_ref_re}), 64'd0);
        repeat (4) step();
        clear_written();

        // Full pass after reset starts from row 0.
        pulse_start(1'b1, 0, c0);
        #1;
        chk("p5_rd0_raddr", 64'(arr_raddr), 64'd0);
        wait_to(c0 + 2 * ROWS + 3);
        check_mem("p5");

        chk("pending_ref_done", 64'(done_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bank_refresh_sequencer.md
Name: bank_refresh_sequencer

Overview:
- Per-bank refresh engine instantiated once per memory bank (8 total), directly downstream of the top-level controller.
- Consumes the controller's per-bank start pulse (start_SR[i]) and walks every row of its gain-cell bank: read a row, then write the same data back.
- Arbitrates the bank's array ports between the external write/read path and refresh.
- Returns ref_done[i] and offs_ref_re[i] to the controller.

Parameters:
- ROWS, 128, rows per bank; must be a power of two.
- AW, 7, row address width; must equal log2(ROWS).
- DW, 64, data word width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_sr  input  1  one-cycle start pulse from the controller.
- we_ext  input  1  external write enable, already decoded to this bank.
- re_ext  input  1  external read enable, already decoded to this bank.
- waddr_ext  input  AW  external write row.
- raddr_ext  input  AW  external read row.
- wdata_ext  input  DW  external write data.
- arr_rd  input  DW  array read data; valid the cycle after arr_re.
- arr_we  output  1  array write enable.
- arr_re  output  1  array read enable.
- arr_waddr  output  AW  array write row.
- arr_raddr  output  AW  array read row.
- arr_wdata  output  DW  array write data.
- ref_done  output  1  one-cycle pulse when a refresh pass completes.
- offs_ref_re  output  1  high while refresh owns the array read port.
- busy  output  1  high from the cycle after start_sr until the ref_done cycle, inclusive.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, row counter 0, data capture register 0.
- States: IDLE, RD, WB, DONE.
- IDLE:
  - Array ports pass through combinationally: arr_we=we_ext, arr_re=re_ext, addresses and data from the *_ext inputs.
  - start_sr=1 -> RD next cycle; row counter cleared to 0.
- RD:
  - arr_re=1, arr_raddr=row, offs_ref_re=1.
  - re_ext is not forwarded to the array. The controller redirects it using offs_ref_re.
  - The write port still passes through we_ext.
  - Always -> WB next cycle.
- WB:
  - arr_rd is captured into the data register on entry to WB, so it holds across stalls.
  - No conflict (we_ext=0): arr_we=1, arr_waddr=row, arr_wdata=captured data. Then either row++ -> RD, or if row==ROWS-1 -> DONE.
  - we_ext=1, waddr_ext==row: the external write wins and carries fresher data. The refresh write is skipped and the row counts as refreshed; advance exactly as in the no-conflict case.
  - we_ext=1, waddr_ext!=row: the external write wins. Stay in WB (stall) holding the captured data; retry next cycle.
  - re_ext in WB is forwarded to the array (read port free); offs_ref_re=0.
- DONE:
  - ref_done=1 for exactly one cycle; busy=1.
  - Ports pass through as in IDLE.
  - -> IDLE.
- Latency: a conflict-free pass is 2*ROWS+1 cycles from the cycle after start_sr through the DONE cycle (257 at default). Each WB stall adds one cycle.
- Row counter is AW bits; it is never incremented past ROWS-1 (no wrap).
- start_sr while not in IDLE is ignored, including in DONE; it never restarts a pass.
- rst asserted mid-pass: return to IDLE next edge; no ref_done pulse; a partially refreshed bank is acceptable.
- start_sr and rst in the same cycle: rst wins.
- offs_ref_re is combinational from the state (RD only) so the controller's read-mux select sees it in the same cycle.

Decomposition:
- Shared package gc_dram_pkg holds:
  - refresh state enum (IDLE, RD, WB, DONE);
  - default widths ROWS/AW/DW, also used by the controller and bank wrappers.
- One natural sub-module: ref_row_counter, an AW-bit counter with synchronous clear, increment enable and a last-row flag (row==ROWS-1).

Test Plan:
- Reset then idle: rst 3 cycles, no start_sr -> all outputs 0. Then we_ext=1, waddr_ext=5, wdata_ext=0xA5 -> arr_we=1, arr_waddr=5, arr_wdata=0xA5 in the same cycle.
- Clean pass: preload row r with r*0x0101, pulse start_sr -> offs_ref_re high on alternate cycles, every row written back unchanged, ref_done single pulse exactly 257 cycles after the start pulse, busy low the next cycle.
- Same-row conflict: at WB of row 10, we_ext=1, waddr_ext=10, data 0xDEAD -> row 10 holds 0xDEAD, no stall, ref_done still at cycle 257.
- Different-row conflict: we_ext=1, waddr_ext=3 during WB of row 20 for 2 cycles -> 2 stall cycles, row 20 rewritten with its original value, ref_done at cycle 259, row 3 holds the external data.
- Read steering: re_ext=1 during an RD cycle -> arr_re driven by refresh with arr_raddr=row, offs_ref_re=1. re_ext=1 during WB -> arr_raddr=raddr_ext, offs_ref_re=0.
- Abort and ignore: second start_sr at row 50 -> ignored, pass continues. rst at row 60 -> IDLE next cycle, no ref_done. A new start_sr after reset -> full 257-cycle pass.
